// File: rtl/ps2_mouse_pkg.sv
// Shared definitions for the PS/2 mouse host controller: command and response
// bytes, init state encoding, status-byte bit positions and packet payloads.
package ps2_mouse_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned DELTA_W = 9;
  localparam int unsigned BTN_W   = 3;
  localparam int unsigned OVF_W   = 2;

  // Host-to-mouse commands
  localparam logic [BYTE_W-1:0] CMD_RESET  = 8'hFF;
  localparam logic [BYTE_W-1:0] CMD_ENABLE = 8'hF4;

  // Mouse-to-host responses
  localparam logic [BYTE_W-1:0] RSP_ACK    = 8'hFA;
  localparam logic [BYTE_W-1:0] RSP_BAT_OK = 8'hAA;
  localparam logic [BYTE_W-1:0] RSP_ID_STD = 8'h00;

  // Status byte (packet byte 0) bit positions
  localparam int unsigned STAT_BTN_LSB = 0;
  localparam int unsigned STAT_BTN_MSB = 2;
  localparam int unsigned STAT_SYNC    = 3;
  localparam int unsigned STAT_XSIGN   = 4;
  localparam int unsigned STAT_YSIGN   = 5;
  localparam int unsigned STAT_XOVF    = 6;
  localparam int unsigned STAT_YOVF    = 7;

  typedef enum logic [3:0] {
    ST_RST_SEND      = 4'd0,
    ST_RST_WAIT_DONE = 4'd1,
    ST_WAIT_ACK      = 4'd2,
    ST_WAIT_BAT      = 4'd3,
    ST_WAIT_ID       = 4'd4,
    ST_EN_SEND       = 4'd5,
    ST_EN_WAIT_DONE  = 4'd6,
    ST_EN_WAIT_ACK   = 4'd7,
    ST_STREAM        = 4'd8,
    ST_FAIL          = 4'd9
  } init_state_e;

  // Status fields kept from byte 0; the always-one sync bit is not stored
  typedef struct packed {
    logic             y_ovf;
    logic             x_ovf;
    logic             y_sign;
    logic             x_sign;
    logic [BTN_W-1:0] buttons;
  } mouse_status_t;

  typedef struct packed {
    logic [OVF_W-1:0]   overflow;
    logic [BTN_W-1:0]   buttons;
    logic [DELTA_W-1:0] dy;
    logic [DELTA_W-1:0] dx;
  } mouse_pkt_t;

  // Sign bit from the status byte becomes bit 8 of each 9-bit delta
  function automatic mouse_pkt_t decode_packet(input mouse_status_t st,
                                               input logic [BYTE_W-1:0] b1,
                                               input logic [BYTE_W-1:0] b2);
    mouse_pkt_t p;
    p.dx       = {st.x_sign, b1};
    p.dy       = {st.y_sign, b2};
    p.buttons  = st.buttons;
    p.overflow = {st.y_ovf, st.x_ovf};
    return p;
  endfunction

endpackage

// File: rtl/ps2_mouse_sequencer_if.sv
// Bus between the mouse sequencer, the PS/2 byte transceiver and the drawing
// logic. master = sequencer side, slave = transceiver/consumer side.
//   tx_data/tx_send        command byte and one-cycle strobe to transceiver
//   tx_done/tx_error       transceiver send completion / timeout pulses
//   rx_data/rx_valid       received byte and one-cycle valid
//   ready/init_fail        init status
//   pkt_*                  decoded stream packet, pkt_valid pulses once per packet
interface ps2_mouse_sequencer_if;
  import ps2_mouse_pkg::*;

  logic [BYTE_W-1:0]  tx_data;
  logic               tx_send;
  logic               tx_done;
  logic               tx_error;
  logic [BYTE_W-1:0]  rx_data;
  logic               rx_valid;
  logic               ready;
  logic               init_fail;
  logic               pkt_valid;
  logic [DELTA_W-1:0] pkt_dx;
  logic [DELTA_W-1:0] pkt_dy;
  logic [BTN_W-1:0]   pkt_buttons;
  logic [OVF_W-1:0]   pkt_overflow;

  modport master (
    output tx_data, tx_send, ready, init_fail,
           pkt_valid, pkt_dx, pkt_dy, pkt_buttons, pkt_overflow,
    input  tx_done, tx_error, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_send, ready, init_fail,
           pkt_valid, pkt_dx, pkt_dy, pkt_buttons, pkt_overflow,
    output tx_done, tx_error, rx_data, rx_valid
  );

endinterface

// File: rtl/ps2_mouse_packet_assembler.sv
// Assembles 3-byte PS/2 stream packets once the mouse is initialised.
// Ports:
//   clk, reset      clock, async active-high reset
//   en_i            high while the sequencer is in STREAM
//   rx_data_i       received byte
//   rx_valid_i      one-cycle valid for rx_data_i
//   pkt_valid_o     one-cycle pulse, cycle after the third byte
//   pkt_o           decoded packet, held until the next one
module ps2_mouse_packet_assembler
  import ps2_mouse_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  input  logic [BYTE_W-1:0] rx_data_i,
  input  logic              rx_valid_i,
  output logic              pkt_valid_o,
  output mouse_pkt_t        pkt_o
);

  localparam int unsigned IDX_W = 2;
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  mouse_status_t     stat_q, stat_d;
  logic [BYTE_W-1:0] b1_q, b1_d;
  mouse_pkt_t        pkt_q, pkt_d;
  logic              pkt_valid_q, pkt_valid_d;
  logic              accept;

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q       <= '0;
      gap_q       <= '0;
      stat_q      <= '0;
      b1_q        <= '0;
      pkt_q       <= '0;
      pkt_valid_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      stat_q      <= stat_d;
      b1_q        <= b1_d;
      pkt_q       <= pkt_d;
      pkt_valid_q <= pkt_valid_d;
    end
  end

  // Byte 0 must carry the always-one sync bit; anything else resyncs silently
  assign accept = en_i && rx_valid_i &&
                  ((idx_q != IDX_W'(0)) || rx_data_i[STAT_SYNC]);

  // Next-state: byte index, inter-byte gap timer and packet capture
  always_comb begin
    idx_d       = idx_q;
    gap_d       = gap_q;
    stat_d      = stat_q;
    b1_d        = b1_q;
    pkt_d       = pkt_q;
    pkt_valid_d = 1'b0;

    if (!en_i) begin
      idx_d = '0;
      gap_d = '0;
    end else if (accept) begin
      gap_d = '0;
      case (idx_q)
        IDX_W'(0): begin
          stat_d.y_ovf   = rx_data_i[STAT_YOVF];
          stat_d.x_ovf   = rx_data_i[STAT_XOVF];
          stat_d.y_sign  = rx_data_i[STAT_YSIGN];
          stat_d.x_sign  = rx_data_i[STAT_XSIGN];
          stat_d.buttons = rx_data_i[STAT_BTN_MSB:STAT_BTN_LSB];
          idx_d          = IDX_W'(1);
        end
        IDX_W'(1): begin
          b1_d  = rx_data_i;
          idx_d = IDX_W'(2);
        end
        default: begin
          pkt_d       = decode_packet(stat_q, b1_q, rx_data_i);
          pkt_valid_d = 1'b1;
          idx_d       = '0;
        end
      endcase
    end else if (idx_q != IDX_W'(0)) begin
      // Stalled mid-packet: drop the partial packet once the gap limit is hit
      if (gap_q >= GAP_LAST) begin
        idx_d = '0;
        gap_d = '0;
      end else begin
        gap_d = gap_q + GAP_W'(1);
      end
    end
  end

  assign pkt_valid_o = pkt_valid_q;
  assign pkt_o       = pkt_q;

endmodule

// File: rtl/ps2_mouse_sequencer.sv
// Host-side PS/2 mouse controller: runs the reset/enable init handshake with
// timeout and retry, then hands received bytes to the packet assembler.
// Ports:
//   clk, reset      clock, async active-high reset
//   bus (master)    transceiver command/response and decoded packet signals
module ps2_mouse_sequencer
  import ps2_mouse_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2500000,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned GAP_CYCLES     = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  ps2_mouse_sequencer_if.master bus
);

  localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RETRY_W = 3;
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  init_state_e        state_q, state_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
  logic               tx_send_q, tx_send_d;
  logic               ready_q, ready_d;
  logic               init_fail_q, init_fail_d;

  // Per-state wait descriptors consumed by the shared wait logic
  logic               done_wait;
  logic               rsp_wait;
  logic               rx_checked;
  logic [BYTE_W-1:0]  rsp_exp;
  init_state_e        done_next;
  init_state_e        rsp_next;
  logic               init_err;

  mouse_pkt_t         pkt;
  logic               pkt_valid;

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RST_SEND;
      tmo_q       <= '0;
      retry_q     <= '0;
      tx_data_q   <= '0;
      tx_send_q   <= 1'b0;
      ready_q     <= 1'b0;
      init_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      retry_q     <= retry_d;
      tx_data_q   <= tx_data_d;
      tx_send_q   <= tx_send_d;
      ready_q     <= ready_d;
      init_fail_q <= init_fail_d;
    end
  end

  // Init sequencing: next state, timeout/retry bookkeeping and command outputs
  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    tx_data_d  = tx_data_q;
    tx_send_d  = 1'b0;
    done_wait  = 1'b0;
    rsp_wait   = 1'b0;
    rx_checked = 1'b0;
    rsp_exp    = '0;
    done_next  = state_q;
    rsp_next   = state_q;
    init_err   = 1'b0;

    case (state_q)
      ST_RST_SEND: begin
        tx_data_d = CMD_RESET;
        tx_send_d = 1'b1;
        state_d   = ST_RST_WAIT_DONE;
      end
      ST_RST_WAIT_DONE: begin
        // Stray bytes while the reset command is on the wire are ignored
        done_wait = 1'b1;
        done_next = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        rsp_wait = 1'b1;
        rsp_exp  = RSP_ACK;
        rsp_next = ST_WAIT_BAT;
      end
      ST_WAIT_BAT: begin
        rsp_wait = 1'b1;
        rsp_exp  = RSP_BAT_OK;
        rsp_next = ST_WAIT_ID;
      end
      ST_WAIT_ID: begin
        rsp_wait = 1'b1;
        rsp_exp  = RSP_ID_STD;
        rsp_next = ST_EN_SEND;
      end
      ST_EN_SEND: begin
        tx_data_d = CMD_ENABLE;
        tx_send_d = 1'b1;
        state_d   = ST_EN_WAIT_DONE;
      end
      ST_EN_WAIT_DONE: begin
        done_wait  = 1'b1;
        done_next  = ST_EN_WAIT_ACK;
        rx_checked = 1'b1;
      end
      ST_EN_WAIT_ACK: begin
        rsp_wait = 1'b1;
        rsp_exp  = RSP_ACK;
        rsp_next = ST_STREAM;
      end
      ST_STREAM, ST_FAIL: begin
        state_d = state_q;
      end
      default: begin
        state_d = ST_RST_SEND;
      end
    endcase

    // tx_error outranks a same-cycle tx_done; a matching event beats the timeout
    if (done_wait || rsp_wait) begin
      if (bus.tx_error) begin
        init_err = 1'b1;
      end else if (done_wait && bus.tx_done) begin
        state_d = done_next;
      end else if (rsp_wait && bus.rx_valid && (bus.rx_data == rsp_exp)) begin
        state_d = rsp_next;
      end else if ((rsp_wait || rx_checked) && bus.rx_valid) begin
        init_err = 1'b1;
      end else if (tmo_q >= TMO_LAST) begin
        init_err = 1'b1;
      end
    end

    if (init_err) begin
      retry_d = retry_q + RETRY_W'(1);
      state_d = (retry_d == RETRY_MAX) ? ST_FAIL : ST_RST_SEND;
    end

    // Timeout restarts on every state entry and only runs while waiting
    if (state_d != state_q) begin
      tmo_d = '0;
    end else if (done_wait || rsp_wait) begin
      tmo_d = tmo_q + TMO_W'(1);
    end else begin
      tmo_d = '0;
    end

    ready_d     = (state_d == ST_STREAM);
    init_fail_d = (state_d == ST_FAIL);
  end

  ps2_mouse_packet_assembler #(
    .GAP_CYCLES (GAP_CYCLES)
  ) u_assembler (
    .clk         (clk),
    .reset       (reset),
    .en_i        (ready_q),
    .rx_data_i   (bus.rx_data),
    .rx_valid_i  (bus.rx_valid),
    .pkt_valid_o (pkt_valid),
    .pkt_o       (pkt)
  );

  assign bus.tx_data      = tx_data_q;
  assign bus.tx_send      = tx_send_q;
  assign bus.ready        = ready_q;
  assign bus.init_fail    = init_fail_q;
  assign bus.pkt_valid    = pkt_valid;
  assign bus.pkt_dx       = pkt.dx;
  assign bus.pkt_dy       = pkt.dy;
  assign bus.pkt_buttons  = pkt.buttons;
  assign bus.pkt_overflow = pkt.overflow;

endmodule

// File: tb/tb_ps2_mouse_sequencer.sv
// Bench for ps2_mouse_sequencer: a scripted mouse answers init commands, then
// directed and random stream traffic is compared against a packet model.
module tb_ps2_mouse_sequencer;
  import ps2_mouse_pkg::*;

  localparam int unsigned TMO     = 400;
  localparam int unsigned RETRIES = 3;
  localparam int unsigned GAP     = 300;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ps2_mouse_sequencer_if bus ();

  ps2_mouse_sequencer #(
    .TIMEOUT_CYCLES (TMO),
    .MAX_RETRIES    (RETRIES),
    .GAP_CYCLES     (GAP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  cmd_q[$];
  logic [22:0] got_q[$];
  logic [22:0] exp_q[$];
  logic [7:0]  sb[$];
  int          sgap[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observe commands and packets away from the active edge
  always @(negedge clk) begin
    if (bus.tx_send) cmd_q.push_back(bus.tx_data);
    if (bus.pkt_valid)
      got_q.push_back({bus.pkt_overflow, bus.pkt_buttons, bus.pkt_dy, bus.pkt_dx});
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic pulse(input logic done, input logic err);
    bus.tx_done  = done;
    bus.tx_error = err;
    tick();
    bus.tx_done  = 1'b0;
    bus.tx_error = 1'b0;
  endtask

  task automatic wait_cmd(input int n_before, input int budget, output int waited);
    waited = 0;
    while (cmd_q.size() <= n_before && waited < budget) begin
      tick();
      waited++;
    end
    check_val($sformatf("cmd%0d_arrived", n_before), 32'(cmd_q.size() > n_before), 1);
  endtask

  function automatic logic [7:0] cmd_at(input int i);
    return (i < cmd_q.size()) ? cmd_q[i] : 8'hxx;
  endfunction

  function automatic logic [22:0] got_at(input int i);
    return (i < got_q.size()) ? got_q[i] : 23'hxx;
  endfunction

  // Reference packet: deltas computed as signed integers, then cast to 9 bits
  function automatic logic [22:0] expect_pkt(input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2);
    int dx, dy;
    logic [7:0] ovf_sh, btn_m;
    dx = int'(b1) - (b0[4] ? 256 : 0);
    dy = int'(b2) - (b0[5] ? 256 : 0);
    ovf_sh = b0 >> 6;
    btn_m  = b0 & 8'h07;
    return {2'(ovf_sh), 3'(btn_m), 9'(dy), 9'(dx)};
  endfunction

  // Stream model: resync on the sync bit, long idle mid-packet drops the partial
  function automatic void model_stream();
    int idx = 0;
    logic [7:0] s0 = 8'h00;
    logic [7:0] s1 = 8'h00;
    foreach (sb[i]) begin
      if (sgap[i] >= int'(GAP) && idx != 0) idx = 0;
      if (idx == 0) begin
        if (sb[i][3]) begin
          s0  = sb[i];
          idx = 1;
        end
      end else if (idx == 1) begin
        s1  = sb[i];
        idx = 2;
      end else begin
        exp_q.push_back(expect_pkt(s0, s1, sb[i]));
        idx = 0;
      end
    end
  endfunction

  task automatic run_batch(input string tag);
    exp_q.delete();
    got_q.delete();
    model_stream();
    foreach (sb[i]) begin
      if (sgap[i] > 0) tick(sgap[i]);
      send_byte(sb[i]);
    end
    tick(4);
    check_val({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i])
      if (i < got_q.size())
        check_val($sformatf("%s_pkt%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    tick(2 * GAP);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    logic [7:0] b0;
    bit trunc_pending;

    reset        = 1'b1;
    bus.tx_done  = 1'b0;
    bus.tx_error = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    tick(3);

    // Reset state
    check_val("rst_tx_data", 32'(bus.tx_data), 0);
    check_val("rst_tx_send", 32'(bus.tx_send), 0);
    check_val("rst_status", 32'({bus.ready, bus.init_fail, bus.pkt_valid}), 0);
    check_val("rst_pkt", 32'({bus.pkt_overflow, bus.pkt_buttons, bus.pkt_dy, bus.pkt_dx}), 0);
    reset = 1'b0;

    // Successful init handshake
    wait_cmd(0, 50, w);
    check_val("init_cmd_reset", 32'(cmd_at(0)), 32'(CMD_RESET));
    tick(3);
    pulse(1'b1, 1'b0);
    tick(5);
    send_byte(RSP_ACK);
    tick(4);
    send_byte(RSP_BAT_OK);
    tick(4);
    send_byte(RSP_ID_STD);
    wait_cmd(1, 50, w);
    check_val("init_cmd_enable", 32'(cmd_at(1)), 32'(CMD_ENABLE));
    tick(3);
    check_val("tx_data_hold", 32'(bus.tx_data), 32'(CMD_ENABLE));
    pulse(1'b1, 1'b0);
    tick(6);
    check_val("ready_before_ack", 32'(bus.ready), 0);
    send_byte(RSP_ACK);
    check_val("ready_after_ack", 32'(bus.ready), 1);
    check_val("init_fail_ok", 32'(bus.init_fail), 0);
    tick(20);
    check_val("init_cmd_count", 32'(cmd_q.size()), 2);

    // Directed stream packets
    sb = '{8'h08, 8'h02, 8'h01};  sgap = '{2, 1, 0};
    run_batch("d1");
    check_val("d1_n", 32'(got_q.size()), 1);
    check_val("d1_val", 32'(got_at(0)), 32'({2'b00, 3'b000, 9'h001, 9'h002}));

    sb = '{8'h39, 8'hFE, 8'hFF};  sgap = '{2, 0, 3};
    run_batch("d2");
    check_val("d2_val", 32'(got_at(0)), 32'({2'b00, 3'b001, 9'h1FF, 9'h1FE}));

    sb = '{8'h00, 8'h08, 8'h02, 8'h01};  sgap = '{2, 2, 2, 2};
    run_batch("d3");
    check_val("d3_n", 32'(got_q.size()), 1);
    check_val("d3_val", 32'(got_at(0)), 32'({2'b00, 3'b000, 9'h001, 9'h002}));

    sb = '{8'h08, 8'h02, 8'h08, 8'h04, 8'h03};  sgap = '{2, 2, 2 * GAP, 2, 2};
    run_batch("d4");
    check_val("d4_n", 32'(got_q.size()), 1);
    check_val("d4_val", 32'(got_at(0)), 32'({2'b00, 3'b000, 9'h003, 9'h004}));
    check_val("pkt_hold_dx", 32'(bus.pkt_dx), 32'h004);
    check_val("pkt_valid_idle", 32'(bus.pkt_valid), 0);

    // Random stream with junk bytes and truncated packets
    sb.delete();
    sgap.delete();
    trunc_pending = 1'b0;
    for (int p = 0; p < 40; p++) begin
      if ($urandom_range(0, 3) == 0) begin
        sb.push_back(8'($urandom) & 8'hF7);
        sgap.push_back(trunc_pending ? int'(2 * GAP) : int'($urandom_range(0, GAP / 4)));
        trunc_pending = 1'b0;
      end
      b0 = 8'($urandom) | 8'h08;
      sb.push_back(b0);
      sgap.push_back(trunc_pending ? int'(2 * GAP) : int'($urandom_range(0, GAP / 4)));
      trunc_pending = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 1) begin
          sb.push_back(8'($urandom));
          sgap.push_back(int'($urandom_range(0, GAP / 4)));
        end
        trunc_pending = 1'b1;
      end else begin
        for (int k = 0; k < 2; k++) begin
          sb.push_back(8'($urandom));
          sgap.push_back(int'($urandom_range(0, GAP / 4)));
        end
      end
    end
    run_batch("rnd");
    check_val("stream_no_cmd", 32'(cmd_q.size()), 2);

    // Reset during WAIT_BAT
    reset = 1'b1;
    tick(2);
    check_val("rst2_pkt", 32'({bus.pkt_overflow, bus.pkt_buttons, bus.pkt_dy, bus.pkt_dx}), 0);
    check_val("rst2_ready", 32'(bus.ready), 0);
    cmd_q.delete();
    reset = 1'b0;
    wait_cmd(0, 50, w);
    tick(2);
    pulse(1'b1, 1'b0);
    tick(3);
    send_byte(RSP_ACK);
    tick(5);
    #2 reset = 1'b1;
    #1;
    check_val("midbat_tx_data", 32'(bus.tx_data), 0);
    check_val("midbat_flags", 32'({bus.tx_send, bus.ready, bus.init_fail}), 0);
    tick(2);
    cmd_q.delete();
    reset = 1'b0;
    wait_cmd(0, 50, w);
    check_val("restart_cmd", 32'(cmd_at(0)), 32'(CMD_RESET));

    // No ACK: timeout, then tx_error, then error winning over done -> FAIL
    tick(2);
    pulse(1'b1, 1'b0);
    wait_cmd(1, int'(3 * TMO), w);
    check_val("retry1_cmd", 32'(cmd_at(1)), 32'(CMD_RESET));
    check_val("tmo_window", 32'(w >= int'(TMO) - 3 && w <= int'(TMO) + 5), 1);
    check_val("not_failed_yet", 32'(bus.init_fail), 0);
    tick(2);
    pulse(1'b0, 1'b1);
    wait_cmd(2, 20, w);
    check_val("retry2_cmd", 32'(cmd_at(2)), 32'(CMD_RESET));
    tick(2);
    pulse(1'b1, 1'b1);
    tick(1);
    check_val("fail_quick", 32'(bus.init_fail), 1);
    tick(int'(3 * TMO));
    check_val("fail_cmd_count", 32'(cmd_q.size()), 3);
    check_val("fail_sticky", 32'({bus.init_fail, bus.ready}), 32'h2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_sequencer.md
Name: ps2_mouse_sequencer

Overview:
Host-side PS/2 mouse controller that sits above the existing PS/2 byte transceiver.
- Runs the mouse init handshake: reset, ACK, self-test pass, device ID, enable data reporting, ACK.
- Then assembles the 3-byte stream packets into decoded movement and button outputs for the drawing logic.
- The bench pairs it with a command-responsive variant of the team's mouse simulator model.

Parameters:
TIMEOUT_CYCLES, 2500000, max wait (clk cycles) for tx_done or any expected response byte during init (50 ms at 50 MHz)
MAX_RETRIES, 3, init attempts before declaring failure (range 1..7)
GAP_CYCLES, 100000, max idle between bytes of one stream packet before the partial packet is discarded

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-high reset
tx_data  out  8  command byte to transceiver
tx_send  out  1  one-cycle command strobe
tx_done  in  1  transceiver finished sending command (pulse)
tx_error  in  1  transceiver send timeout (pulse)
rx_data  in  8  received byte
rx_valid  in  1  rx_data valid (one-cycle pulse)
ready  out  1  high while in STREAM
init_fail  out  1  high in FAIL; cleared only by reset
pkt_valid  out  1  one-cycle pulse, new packet on pkt_* outputs
pkt_dx  out  9  signed X delta {b0[4], b1}
pkt_dy  out  9  signed Y delta {b0[5], b2}
pkt_buttons  out  3  {middle, right, left} = b0[2:0]
pkt_overflow  out  2  {y_ovf, x_ovf} = b0[7:6]

Behaviour:
- Reset (async assert, sync release):
  - State goes to RST_SEND; retry count and timeout count = 0.
  - All outputs = 0: tx_data=0x00, tx_send, ready, init_fail, pkt_valid, pkt_* all 0.
  - Reset mid-transfer abandons everything; tx_send must never glitch high during reset.
- States:
  - RST_SEND: tx_data=0xFF, tx_send=1 for exactly one cycle -> RST_WAIT_DONE.
  - RST_WAIT_DONE: tx_done -> WAIT_ACK; rx_valid ignored here.
  - WAIT_ACK: rx 0xFA -> WAIT_BAT.
  - WAIT_BAT: rx 0xAA -> WAIT_ID.
  - WAIT_ID: rx 0x00 -> EN_SEND.
  - EN_SEND: tx_data=0xF4, one-cycle tx_send -> EN_WAIT_DONE.
  - EN_WAIT_DONE: tx_done -> EN_WAIT_ACK.
  - EN_WAIT_ACK: rx 0xFA -> STREAM.
  - STREAM: ready=1; packet assembly.
  - FAIL: init_fail=1; terminal until reset.
- tx_data holds its value after the strobe until the next command.
- Timeout counter clears on every state entry and counts in every init wait state.
- Init error:
  - Triggers: reaching TIMEOUT_CYCLES, tx_error, or any unexpected rx byte in a WAIT_* state.
  - Action: retry count +1. If new count == MAX_RETRIES -> FAIL, else -> RST_SEND.
  - If tx_done and tx_error arrive in the same cycle, tx_error wins.
- STREAM assembly (byte index 0..2):
  - idx0: byte accepted only if bit3=1, else dropped silently (resync).
  - idx1 and idx2: any byte accepted.
  - Gap counter clears on each accepted byte. If it reaches GAP_CYCLES with idx != 0, idx returns to 0 and the partial packet is discarded.
- Packet output:
  - pkt_valid pulses the cycle after rx_valid of byte 2 (latency 1).
  - pkt_* update on that same cycle and hold until the next packet.
  - Sign extension is exactly as in the port formulas; no saturation; overflow bits are passed through raw.
- Retry count is never cleared by a successful init; it only clears on reset.

Decomposition:
- Shared package ps2_mouse_pkg:
  - Command constants CMD_RESET=0xFF, CMD_ENABLE=0xF4.
  - Response constants RSP_ACK=0xFA, RSP_BAT_OK=0xAA, RSP_ID_STD=0x00.
  - Init state enum.
  - Status-byte bit-position constants.
- One sub-module, ps2_mouse_packet_assembler: STREAM byte index, gap counter, resync and pkt_* registers, enabled by ready.

Test Plan:
- Model replies FA, AA, 00 after 0xFF, then FA after 0xF4 -> exactly two tx_send pulses (0xFF then 0xF4); ready=1 the cycle after the final FA; init_fail=0.
- In STREAM, rx 08, 02, 01 -> one pkt_valid; dx=+2, dy=+1, buttons=000, overflow=00.
- rx 39, FE, FF -> dx=-2 (0x1FE), dy=-1 (0x1FF), buttons=001.
- rx 00, then 08, 02, 01 -> 00 dropped; exactly one pkt_valid with dx=+2.
- rx 08, 02, then silence > GAP_CYCLES, then 08, 04, 03 -> single packet with dx=+4, dy=+3.
- Init timeout and reset:
  - Mouse never ACKs, MAX_RETRIES=3 -> three 0xFF commands, then init_fail=1 and no further tx_send.
  - Reset asserted mid-WAIT_BAT -> all outputs 0 immediately; init restarts with 0xFF.
